board_io_ctrl: RTL and testbench

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

---
 rtl/board_io_ctrl.sv | 127 ++++++++++++
 tb/tb_board_io_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: synchronised + debounced buttons/switches with press/release pulses and
// registered RGB LED drive. Define BOARD_IO_PWM_EN to add global PWM brightness dimming.
module board_io_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int NUM_SW          = 4,
  parameter int NUM_RGB         = 4,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int PWM_BITS        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BTN-1:0]     btn_in,
  input  logic [NUM_SW-1:0]      sw_in,
  output logic [NUM_BTN-1:0]     btn_level,
  output logic [NUM_BTN-1:0]     btn_press,
  output logic [NUM_BTN-1:0]     btn_release,
  output logic [NUM_SW-1:0]      sw_level,
  input  logic [3*NUM_RGB-1:0]   rgb_on,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [3*NUM_RGB-1:0]   rgb_out
);

  localparam int NUM_CH = NUM_BTN + NUM_SW;
  localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0]    raw_in;
  logic [NUM_CH-1:0]    sync1_q, sync2_q;
  logic [NUM_CH-1:0]    deb_level;
  logic [NUM_CH-1:0]    level_q;
  logic [NUM_BTN-1:0]   press_q, release_q;
  logic [3*NUM_RGB-1:0] rgb_q, rgb_d;

  // Buttons occupy the low channels, switches the high ones.
  assign raw_in = {sw_in, btn_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_deb
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lvl_q, lvl_d;

    // Counter only runs while the input disagrees with the accepted level.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q[gi] != lvl_q) begin
        if (cnt_q == CNT_LAST) begin
          lvl_d = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign deb_level[gi] = lvl_q;
  end

  // Output stage: level and edge pulses are registered together so a pulse
  // coincides with the first cycle the new level is visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      level_q   <= deb_level;
      press_q   <= deb_level[NUM_BTN-1:0] & ~level_q[NUM_BTN-1:0];
      release_q <= ~deb_level[NUM_BTN-1:0] & level_q[NUM_BTN-1:0];
    end
  end

  assign btn_level   = level_q[NUM_BTN-1:0];
  assign sw_level    = level_q[NUM_CH-1:NUM_BTN];
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BOARD_IO_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                pwm_lit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  // All-ones brightness means fully on, not (2^N-1)/2^N duty.
  assign pwm_lit = (&brightness) || (pwm_cnt_q < brightness);
  assign rgb_d   = rgb_on & {(3*NUM_RGB){pwm_lit}};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign rgb_d = rgb_on;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_out = rgb_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Scoreboarded bench for board_io_ctrl: a sample-history reference model predicts every
// cycle's outputs; directed scenarios add latency, glitch, PWM duty and reset checks.
module tb_board_io_ctrl;

  localparam int NB  = 4;
  localparam int NS  = 4;
  localparam int NR  = 4;
  localparam int DEB = 4;
  localparam int PB  = 8;
  localparam int NCH = NB + NS;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NB-1:0]   btn_in = '0;
  logic [NS-1:0]   sw_in = '0;
  logic [3*NR-1:0] rgb_on = '0;
  logic [PB-1:0]   brightness = '0;
  logic [NB-1:0]   btn_level, btn_press, btn_release;
  logic [NS-1:0]   sw_level;
  logic [3*NR-1:0] rgb_out;

  board_io_ctrl #(
    .NUM_BTN(NB), .NUM_SW(NS), .NUM_RGB(NR), .DEBOUNCE_CYCLES(DEB), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .sw_in(sw_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .sw_level(sw_level), .rgb_on(rgb_on), .brightness(brightness), .rgb_out(rgb_out)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [NB-1:0]   bl;
    logic [NB-1:0]   bp;
    logic [NB-1:0]   br;
    logic [NS-1:0]   sl;
    logic [3*NR-1:0] rgb;
  } exp_t;

  // Reference model: a channel's level flips once its last DEB synchronised
  // samples all disagree with it; samples reach the debouncer two edges late.
  bit          pipe    [NCH][$];
  bit          hist    [NCH][$];
  bit          lvl_int [NCH];
  bit          lvl_out [NCH];
  int unsigned edges_since_reset;
  exp_t        exp_q[$];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      pipe[c].delete();
      pipe[c].push_back(1'b0);
      pipe[c].push_back(1'b0);
      hist[c].delete();
      lvl_int[c] = 1'b0;
      lvl_out[c] = 1'b0;
    end
    edges_since_reset = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    exp_t           e;
    logic [NCH-1:0] raw, lv_new, lv_old;
    bit             s, all_diff, lit;
    int unsigned    phase;
    raw = {sw_in, btn_in};
    for (int c = 0; c < NCH; c++) begin
      s = pipe[c].pop_front();
      pipe[c].push_back(raw[c]);
      lv_old[c]  = lvl_out[c];
      lv_new[c]  = lvl_int[c];
      lvl_out[c] = lvl_int[c];
      hist[c].push_back(s);
      if (hist[c].size() > DEB) void'(hist[c].pop_front());
      if (hist[c].size() == DEB) begin
        all_diff = 1'b1;
        for (int k = 0; k < hist[c].size(); k++)
          if (hist[c][k] == lvl_int[c]) all_diff = 1'b0;
        if (all_diff) lvl_int[c] = !lvl_int[c];
      end
    end
    e.bl  = lv_new[NB-1:0];
    e.sl  = lv_new[NCH-1:NB];
    e.bp  = lv_new[NB-1:0] & ~lv_old[NB-1:0];
    e.br  = ~lv_new[NB-1:0] & lv_old[NB-1:0];
    phase = edges_since_reset % (1 << PB);
`ifdef BOARD_IO_PWM_EN
    lit = (brightness == {PB{1'b1}}) || (phase < brightness);
`else
    lit = 1'b1;
`endif
    e.rgb = lit ? rgb_on : '0;
    edges_since_reset++;
    exp_q.push_back(e);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge();
    end
  end

  // Monitor: one comparison per clock, decoupled from the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outputs", {btn_level, btn_press, btn_release, sw_level, rgb_out}, '0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {btn_level, btn_press, btn_release, sw_level, rgb_out}, e);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  wire [NCH-1:0] lvl_all   = {sw_level, btn_level};
  wire [NCH-1:0] press_all = {{NS{1'b0}}, btn_press};
  wire [NCH-1:0] rel_all   = {{NS{1'b0}}, btn_release};

  // Call right after driving a change at a negedge; index 0 is the negedge after
  // the first sampling edge.
  task automatic track(input int idx, input logic target, input int ncyc,
                       output int change_at, output int pulses, output logic pulse_at_change);
    logic p;
    change_at = -1;
    pulses = 0;
    pulse_at_change = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      p = target ? press_all[idx] : rel_all[idx];
      if (p) pulses++;
      if (change_at < 0 && lvl_all[idx] == target) begin
        change_at = i;
        pulse_at_change = p;
      end
    end
  endtask

  initial begin
    int   chg, pls, cnt, rise_b, rise_s;
    logic pac;
    int   blist[3];
    int   bitcnt[3*NR];
    int   exp_cnt;
    blist[0] = 64;
    blist[1] = 0;
    blist[2] = 255;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", {btn_level, btn_press, btn_release, sw_level, rgb_out}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    btn_in[0] = 1'b1;
    track(0, 1'b1, 20, chg, pls, pac);
    check("btn0_rise_latency", chg, DEB + 2);
    check("btn0_press_count", pls, 1);
    check("btn0_press_with_rise", pac, 1);
    $display("scenario press: rise_at=%0d press_pulses=%0d", chg, pls);

    cnt = 0;
    btn_in[1] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 2) btn_in[1] = 1'b0;
      if (btn_level[1] | btn_press[1] | btn_release[1]) cnt++;
    end
    check("btn1_glitch_ignored", cnt, 0);
    $display("scenario glitch: active_cycles=%0d", cnt);

    btn_in[0] = 1'b0;
    repeat (12) @(negedge clk);
    btn_in[0] = 1'b1;
    sw_in[3] = 1'b1;
    rise_b = -1;
    rise_s = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rise_b < 0 && btn_level[0]) rise_b = i;
      if (rise_s < 0 && sw_level[3]) rise_s = i;
    end
    check("btn0_sim_rise", rise_b, DEB + 2);
    check("sw3_sim_rise", rise_s, DEB + 2);
    btn_in[0] = 1'b0;
    track(0, 1'b0, 20, chg, pls, pac);
    check("btn0_fall_latency", chg, DEB + 2);
    check("btn0_release_count", pls, 1);
    check("btn0_release_with_fall", pac, 1);
    $display("scenario simultaneous: btn_rise=%0d sw_rise=%0d fall=%0d", rise_b, rise_s, chg);

    rgb_on = 12'hFFF;
    for (int b = 0; b < 3; b++) begin
      brightness = PB'(blist[b]);
      for (int j = 0; j < 3*NR; j++) bitcnt[j] = 0;
      for (int i = 0; i < 512; i++) begin
        @(negedge clk);
        for (int j = 0; j < 3*NR; j++) if (rgb_out[j]) bitcnt[j]++;
      end
`ifdef BOARD_IO_PWM_EN
      exp_cnt = (blist[b] == 255) ? 512 : 2 * blist[b];
`else
      exp_cnt = 512;
`endif
      for (int j = 0; j < 3*NR; j++) check($sformatf("duty_b%0d_bit%0d", blist[b], j), bitcnt[j], exp_cnt);
      $display("scenario duty: brightness=%0d bit0_high=%0d", blist[b], bitcnt[0]);
    end

`ifdef BOARD_IO_PWM_EN
    brightness = 8'hFF;
`else
    brightness = PB'($urandom);
`endif
    rgb_on = 12'h5A5;
    @(negedge clk);
    check("rgb_passthrough", rgb_out, 12'h5A5);
    $display("scenario passthrough: rgb_out=%0h", rgb_out);

    rgb_on = 12'hFFF;
    brightness = 8'hFF;
    repeat (3) @(negedge clk);
    btn_in[2] = 1'b1;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("async_reset_clear", {btn_level, btn_press, btn_release, sw_level, rgb_out}, '0);
    @(negedge clk);
    reset = 1'b0;
    track(2, 1'b1, 20, chg, pls, pac);
    check("btn2_rise_after_reset", chg, DEB + 2);
    check("btn2_press_after_reset", pls, 1);
    $display("scenario reset: rise_after_release=%0d", chg);

    for (int n = 0; n < 3000; n++) begin
      int b;
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, NCH - 1);
        if (b < NB) btn_in[b] = ~btn_in[b];
        else sw_in[b-NB] = ~sw_in[b-NB];
      end
      if ($urandom_range(0, 30) == 0) rgb_on = 12'($urandom);
      if ($urandom_range(0, 100) == 0) begin
        case ($urandom_range(0, 2))
          0: brightness = '0;
          1: brightness = '1;
          default: brightness = PB'($urandom);
        endcase
      end
    end
    repeat (4) @(negedge clk);
    $display("scenario random: cycles=3000 checks_so_far=%0d", checks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
